// File: rtl/mandel_coord_gen_pkg.sv
// Shared constants and types for the Mandelbrot coordinate generator.
// All fixed-point values are 32-bit signed two's complement with FRACTION fraction bits.
package mandel_coord_gen_pkg;

  localparam int unsigned FRACTION = 20;
  localparam int unsigned FP_W     = 32;

  localparam logic signed [FP_W-1:0] ONE  = 32'sd1 <<< FRACTION;
  localparam logic signed [FP_W-1:0] FOUR = 32'sd4 <<< FRACTION;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/mandel_coord_gen_if.sv
// Frame request and pixel stream bundle between the generator and its neighbours.
// The master side is the coordinate generator itself.
interface mandel_coord_gen_if
  import mandel_coord_gen_pkg::*;
#(
  parameter int unsigned H_RES = 640,
  parameter int unsigned V_RES = 480
);

  localparam int unsigned PxW = $clog2(H_RES);
  localparam int unsigned PyW = $clog2(V_RES);

  logic                   start;
  logic signed [FP_W-1:0] x0;
  logic signed [FP_W-1:0] y0;
  logic signed [FP_W-1:0] dx;
  logic signed [FP_W-1:0] dy;

  logic                   out_valid;
  logic                   out_ready;
  logic signed [FP_W-1:0] cr;
  logic signed [FP_W-1:0] ci;
  logic [PxW-1:0]         px;
  logic [PyW-1:0]         py;
  logic                   last;

  logic                   busy;
  logic                   frame_done;

  modport master (
    input  start,
    input  x0,
    input  y0,
    input  dx,
    input  dy,
    input  out_ready,
    output out_valid,
    output cr,
    output ci,
    output px,
    output py,
    output last,
    output busy,
    output frame_done
  );

  modport slave (
    output start,
    output x0,
    output y0,
    output dx,
    output dy,
    output out_ready,
    input  out_valid,
    input  cr,
    input  ci,
    input  px,
    input  py,
    input  last,
    input  busy,
    input  frame_done
  );

endinterface

// File: rtl/mandel_axis_counter.sv
// One scan axis: an index counter paired with a fixed-point accumulator.
// On wrap the index returns to 0 and the accumulator to the latched base value.
module mandel_axis_counter
  import mandel_coord_gen_pkg::*;
#(
  parameter int unsigned Count = 2,
  parameter int unsigned IdxW  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_load,
  input  logic signed [FP_W-1:0] i_load_val,
  input  logic                   i_step,
  input  logic signed [FP_W-1:0] i_base,
  input  logic signed [FP_W-1:0] i_delta,
  output logic [IdxW-1:0]        o_idx,
  output logic signed [FP_W-1:0] o_acc,
  output logic                   o_carry
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(Count - 1);

  logic [IdxW-1:0]        r_idx;
  logic signed [FP_W-1:0] r_acc;
  logic                   w_carry;

  assign w_carry = (r_idx == LastIdx);

  // Load wins over step: a new frame always starts from the freshly supplied origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (i_load) begin
      r_idx <= '0;
      r_acc <= i_load_val;
    end else if (i_step) begin
      if (w_carry) begin
        r_idx <= '0;
        r_acc <= i_base;
      end else begin
        r_idx <= r_idx + 1'b1;
        r_acc <= r_acc + i_delta;
      end
    end
  end

  assign o_idx   = r_idx;
  assign o_acc   = r_acc;
  assign o_carry = w_carry;

endmodule

// File: rtl/mandel_coord_gen.sv
// Raster-scan generator of complex c coordinates for a Mandelbrot iteration stage.
// Emits one pixel per accepted transfer, left to right then top to bottom.
module mandel_coord_gen #(
  parameter int unsigned H_RES    = 640,
  parameter int unsigned V_RES    = 480,
  parameter int unsigned FRACTION = mandel_coord_gen_pkg::FRACTION
) (
  input logic               clk,
  input logic               rst_n,
  mandel_coord_gen_if.master bus
);

  import mandel_coord_gen_pkg::*;

  localparam int unsigned PxW = $clog2(H_RES);
  localparam int unsigned PyW = $clog2(V_RES);

  if (H_RES < 2 || V_RES < 2 || FRACTION >= FP_W) begin : g_bad_param
    $error("mandel_coord_gen: unsupported parameter set");
  end

  state_e                 r_state;
  state_e                 w_state_next;
  logic                   r_frame_done;
  logic                   w_frame_done_next;

  logic signed [FP_W-1:0] r_x0;
  logic signed [FP_W-1:0] r_y0;
  logic signed [FP_W-1:0] r_dx;
  logic signed [FP_W-1:0] r_dy;
  logic signed [FP_W-1:0] w_neg_dy;

  logic                   w_start_frame;
  logic                   w_out_valid;
  logic                   w_xfer;
  logic                   w_last;
  logic                   w_col_carry;
  logic                   w_row_carry;
  logic                   w_row_step;
  logic [PxW-1:0]         w_px;
  logic [PyW-1:0]         w_py;
  logic signed [FP_W-1:0] w_cr;
  logic signed [FP_W-1:0] w_ci;

  assign w_start_frame = (r_state == StIdle) && bus.start;
  assign w_out_valid   = (r_state == StRun);
  assign w_xfer        = w_out_valid && bus.out_ready;
  assign w_last        = w_out_valid && w_col_carry && w_row_carry;
  assign w_row_step    = w_xfer && w_col_carry;
  // Rows descend in the imaginary axis, so the row accumulator adds -dy.
  assign w_neg_dy      = -r_dy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x0 <= '0;
      r_y0 <= '0;
      r_dx <= '0;
      r_dy <= '0;
    end else if (w_start_frame) begin
      r_x0 <= bus.x0;
      r_y0 <= bus.y0;
      r_dx <= bus.dx;
      r_dy <= bus.dy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_frame_done_next = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_next = StRun;
        end
      end
      StRun: begin
        if (w_xfer && w_last) begin
          w_state_next      = StIdle;
          w_frame_done_next = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  mandel_axis_counter #(
    .Count (H_RES),
    .IdxW  (PxW)
  ) u_col (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_start_frame),
    .i_load_val (bus.x0),
    .i_step     (w_xfer),
    .i_base     (r_x0),
    .i_delta    (r_dx),
    .o_idx      (w_px),
    .o_acc      (w_cr),
    .o_carry    (w_col_carry)
  );

  mandel_axis_counter #(
    .Count (V_RES),
    .IdxW  (PyW)
  ) u_row (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_start_frame),
    .i_load_val (bus.y0),
    .i_step     (w_row_step),
    .i_base     (r_y0),
    .i_delta    (w_neg_dy),
    .o_idx      (w_py),
    .o_acc      (w_ci),
    .o_carry    (w_row_carry)
  );

  assign bus.out_valid  = w_out_valid;
  assign bus.cr         = w_cr;
  assign bus.ci         = w_ci;
  assign bus.px         = w_px;
  assign bus.py         = w_py;
  assign bus.last       = w_last;
  assign bus.busy       = w_out_valid;
  assign bus.frame_done = r_frame_done;

endmodule

// File: doc/mandel_coord_gen.md
MANDEL_COORD_GEN -- requirements
Module: mandel_coord_gen

Interface
REQ-001 SHALL have parameter H_RES, default 640, pixels per row (>=2).
REQ-002 SHALL have parameter V_RES, default 480, rows per frame (>=2).
REQ-003 SHALL have parameter FRACTION, default 20, fraction bits of all 32-bit signed fixed-point values.
REQ-004 SHALL have port clk  input  1  the single clock, rising edge active.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request to begin a frame.
REQ-007 SHALL have port x0  input  32  signed real part of the top-left pixel.
REQ-008 SHALL have port y0  input  32  signed imaginary part of the top-left pixel.
REQ-009 SHALL have port dx  input  32  signed real increment per column.
REQ-010 SHALL have port dy  input  32  signed imaginary decrement per row.
REQ-011 SHALL have port out_valid  output  1  cr/ci/px/py/last hold a pixel.
REQ-012 SHALL have port out_ready  input  1  downstream iteration stage accepts the pixel.
REQ-013 SHALL have port cr  output  32  real part of c for the current pixel.
REQ-014 SHALL have port ci  output  32  imaginary part of c for the current pixel.
REQ-015 SHALL have port px  output  clog2(H_RES)  column index.
REQ-016 SHALL have port py  output  clog2(V_RES)  row index.
REQ-017 SHALL have port last  output  1  current pixel is (H_RES-1, V_RES-1).
REQ-018 SHALL have port busy  output  1  a frame is in progress.
REQ-019 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel is accepted.

Function
REQ-020 SHALL implement states IDLE and RUN; busy SHALL be 1 exactly in RUN.
REQ-021 In IDLE, start=1 SHALL latch x0, y0, dx, dy and enter RUN on the same edge.
REQ-022 First RUN cycle SHALL present out_valid=1, cr=x0, ci=y0, px=0, py=0 (latency 1 cycle from start).
REQ-023 A transfer SHALL occur on any edge with out_valid=1 and out_ready=1.
REQ-024 Without a transfer, out_valid and all payload outputs SHALL hold stable.
REQ-025 On transfer with px<H_RES-1: px+1, cr+dx, py and ci unchanged.
REQ-026 On transfer with px=H_RES-1 and py<V_RES-1: px=0, cr=latched x0, py+1, ci-dy.
REQ-027 On transfer with last=1: enter IDLE, out_valid=0, frame_done=1 for exactly the next cycle.
REQ-028 last SHALL be combinational from px/py and qualified by out_valid.
REQ-029 cr/ci arithmetic SHALL be 32-bit two's-complement, wrapping modulo 2^32, no saturation.
REQ-030 start, x0, y0, dx, dy SHALL be ignored while in RUN; latched values SHALL not change mid-frame.
REQ-031 start=1 in the frame_done cycle SHALL begin a new frame (back-to-back frames, one idle cycle).
REQ-032 out_valid SHALL be asserted continuously within a frame; the only bubbles are out_ready=0.

Reset
REQ-033 rst_n=0 SHALL asynchronously force IDLE, out_valid=0, busy=0, frame_done=0, last=0, px=0, py=0, cr=0, ci=0, latched x0/y0/dx/dy=0.
REQ-034 Reset asserted mid-frame SHALL abandon the frame with no frame_done; release SHALL need a new start.
REQ-035 Reset deassertion SHALL be synchronised by the existing reset synchroniser outside this block.

Structure
REQ-036 Shared package SHALL hold FRACTION, fixed-point width (32), the Q-format constants ONE and FOUR, and the state enum.
REQ-037 One sub-module mandel_axis_counter (index + fixed-point accumulator, wrap to base, carry-out) SHALL be instantiated twice, for columns and rows.
REQ-038 Outputs SHALL be registered; no combinational path from out_ready to out_valid.

Verification (H_RES=4, V_RES=3, FRACTION=20)
REQ-039 x0=0xFFE00000 (-2.0), y0=0x00100000 (1.0), dx=0x00080000, dy=0x00100000, out_ready=1 -> 12 pixels, cr -2.0,-1.5,-1.0,-0.5 per row, ci 1.0,0.0,-1.0, last only on 12th, frame_done one cycle later.
REQ-040 Same frame, out_ready toggled 1/0 each cycle -> same 12-pixel sequence, payload stable on every stalled cycle, 24 RUN cycles.
REQ-041 start pulsed in RUN with new x0=0 -> ignored; current frame unchanged; next frame uses the value present at the next IDLE start.
REQ-042 rst_n low after 5 transfers -> outputs per REQ-033 immediately (asynchronously), no frame_done; after release and start -> frame restarts at px=0, py=0.
REQ-043 x0=0x7FF00000, dx=0x00100000 -> second cr=0x80000000 (wrap, no saturation).
REQ-044 start held high continuously -> frames back-to-back with exactly one out_valid=0 cycle (frame_done) between them.
